quadrature_step_decoder: RTL



---
 rtl/qdec_pkg.sv | 46 ++++
 rtl/qdec_input_filter.sv | 47 ++++
 rtl/quadrature_step_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/qdec_pkg.sv
// rtl/qdec_pkg.sv - shared types, Gray-code phase constants and step classification for the quadrature decoder
package qdec_pkg;

   typedef enum logic {
      QDEC_INIT  = 1'b0,
      QDEC_TRACK = 1'b1
   } qdec_state_t;

   typedef enum logic [1:0] {
      STEP_NONE    = 2'd0,
      STEP_FWD     = 2'd1,
      STEP_REV     = 2'd2,
      STEP_ILLEGAL = 2'd3
   } qdec_step_t;

   // Phases as {A,B}; forward order is 00 -> 01 -> 11 -> 10 -> 00
   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   function automatic logic [1:0] qdec_fwd_next(input logic [1:0] ph);
      logic [1:0] nxt;
      case (ph)
         PH_00:   nxt = PH_01;
         PH_01:   nxt = PH_11;
         PH_11:   nxt = PH_10;
         default: nxt = PH_00;
      endcase
      return nxt;
   endfunction

   function automatic qdec_step_t qdec_decode(input logic [1:0] prev, input logic [1:0] next);
      qdec_step_t step;
      if (next == prev)
         step = STEP_NONE;
      else if ((prev ^ next) == 2'b11)
         step = STEP_ILLEGAL;
      else if (next == qdec_fwd_next(prev))
         step = STEP_FWD;
      else
         step = STEP_REV;
      return step;
   endfunction

endpackage

// File: rtl/qdec_input_filter.sv
// rtl/qdec_input_filter.sv - per-channel synchroniser and consecutive-cycle glitch filter with bypass
module qdec_input_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_pin,
   input  logic i_bypass,
   output logic o_filtered
);

   localparam int CW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_filtered;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];

   // Bypass is combinational so the settle logic sees the live synced value on its last INIT cycle
   assign o_filtered = i_bypass ? w_synced : r_filtered;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync     <= '0;
         r_cnt      <= '0;
         r_filtered <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         if (i_bypass) begin
            r_filtered <= w_synced;
            r_cnt      <= '0;
         end else if (w_synced == r_filtered) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_filtered <= w_synced;
            r_cnt      <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/quadrature_step_decoder.sv
// rtl/quadrature_step_decoder.sv - 4x quadrature decoder producing increase/decrease/step_error pulses
// Optional saturating illegal-transition counter on err_count when QDEC_ERROR_COUNT_EN is defined.
module quadrature_step_decoder
   import qdec_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       enable,
   output logic       increase,
   output logic       decrease,
   output logic       direction,
   output logic       step_error
`ifdef QDEC_ERROR_COUNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam int SW = $clog2(SYNC_STAGES + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SYNC_STAGES);

   qdec_state_t r_state;
   logic [SW-1:0] r_settle;
   logic [1:0]    r_prev_ab;
   logic          w_bypass;
   logic          w_filt_a;
   logic          w_filt_b;
   logic [1:0]    w_ab;
   qdec_step_t    w_step;

   assign w_bypass = (r_state == QDEC_INIT);
   assign w_ab     = {w_filt_a, w_filt_b};
   assign w_step   = qdec_decode(r_prev_ab, w_ab);

   qdec_input_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter_a (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_pin      (enc_a),
      .i_bypass   (w_bypass),
      .o_filtered (w_filt_a)
   );

   qdec_input_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter_b (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_pin      (enc_b),
      .i_bypass   (w_bypass),
      .o_filtered (w_filt_b)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= QDEC_INIT;
         r_settle   <= '0;
         r_prev_ab  <= PH_00;
         increase   <= 1'b0;
         decrease   <= 1'b0;
         step_error <= 1'b0;
         direction  <= 1'b0;
      end else begin
         r_prev_ab <= w_ab;
         if (r_state == QDEC_INIT) begin
            increase   <= 1'b0;
            decrease   <= 1'b0;
            step_error <= 1'b0;
            if (r_settle == SETTLE_LAST)
               r_state <= QDEC_TRACK;
            else
               r_settle <= r_settle + 1'b1;
         end else begin
            increase   <= (w_step == STEP_FWD) && enable;
            decrease   <= (w_step == STEP_REV) && enable;
            step_error <= (w_step == STEP_ILLEGAL);
            if (w_step == STEP_FWD)
               direction <= 1'b1;
            else if (w_step == STEP_REV)
               direction <= 1'b0;
         end
      end
   end

`ifdef QDEC_ERROR_COUNT_EN
   logic [7:0] r_err_count;

   assign err_count = r_err_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_err_count <= 8'h00;
      else if ((r_state == QDEC_TRACK) && (w_step == STEP_ILLEGAL) && (r_err_count != 8'hFF))
         r_err_count <= r_err_count + 8'h01;
   end
`endif

endmodule
